// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter sharing one synchronous single-port data RAM between N_CORES cores.
module data_mem_arbiter #(
  parameter int N_CORES = 4,
  parameter int MEM_AW  = 10
) (
  input  logic                  clock,
  input  logic                  async_reset,
  input  logic [N_CORES-1:0]    req_valid,
  input  logic [N_CORES-1:0]    req_write,
  input  logic [32*N_CORES-1:0] req_addr,
  input  logic [32*N_CORES-1:0] req_wdata,
  input  logic [4*N_CORES-1:0]  req_be,
  output logic [N_CORES-1:0]    stall,
  output logic [N_CORES-1:0]    ack,
  output logic [31:0]           rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata
);
  localparam int GW = $clog2(N_CORES);
  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT, DONE} state_t;
  state_t              r_state;
  logic [GW-1:0]       r_g, r_last, w_win, w_idx;
  logic                w_found;
  logic                w_unused;
  logic [N_CORES-1:0]  r_ack;
  logic [31:0]         r_rdata, r_mem_wdata;
  logic                r_mem_en, r_mem_we;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [3:0]          r_mem_be;
  logic [MEM_AW-1:0]   w_addr  [N_CORES];
  logic [31:0]         w_wdata [N_CORES];
  logic [3:0]          w_be    [N_CORES];
  // byte offset and bits above the RAM window are deliberately dropped
  for (genvar i = 0; i < N_CORES; i++) begin : g_unpack
    assign w_addr[i]  = req_addr[32*i+2 +: MEM_AW];
    assign w_wdata[i] = req_wdata[32*i +: 32];
    assign w_be[i]    = req_be[4*i +: 4];
  end
  assign w_unused = ^req_addr;
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int o = 1; o <= N_CORES; o++) begin
      w_idx = GW'((int'(r_last) + o) % N_CORES);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_state     <= IDLE;
      r_g         <= '0;
      r_last      <= GW'(N_CORES - 1);
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_g         <= w_win;
          r_mem_en    <= 1'b1;
          r_mem_we    <= req_write[w_win];
          r_mem_addr  <= w_addr[w_win];
          r_mem_wdata <= w_wdata[w_win];
          r_mem_be    <= w_be[w_win];
          r_state     <= ACCESS;
        end
        ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mem_we) r_ack[r_g] <= 1'b1;
          r_state  <= r_mem_we ? DONE : READ_WAIT;
        end
        READ_WAIT: begin
          r_rdata    <= mem_rdata;
          r_ack[r_g] <= 1'b1;
          r_state    <= DONE;
        end
        default: begin
          r_ack   <= '0;
          r_last  <= r_g;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign stall     = req_valid & ~r_ack;
  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a behavioural byte-masked RAM.
module tb_data_mem_arbiter;
  localparam int N = 4;
  logic           clock = 1'b0;
  logic           async_reset = 1'b0;
  logic [N-1:0]   req_valid = '0, req_write = '0;
  logic [32*N-1:0] req_addr = '0, req_wdata = '0;
  logic [4*N-1:0] req_be = '0;
  logic [N-1:0]   stall, ack;
  logic [31:0]    rdata, mem_wdata, mem_rdata = '0;
  logic           mem_en, mem_we;
  logic [9:0]     mem_addr;
  logic [3:0]     mem_be;
  logic [31:0]    ram [1024];
  int n_checks = 0, n_fail = 0;

  data_mem_arbiter #(.N_CORES(N), .MEM_AW(10)) dut (
    .clock(clock), .async_reset(async_reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .stall(stall), .ack(ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_en) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int c, input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    req_write[c] = wr;
    req_addr[32*c +: 32] = addr;
    req_wdata[32*c +: 32] = wd;
    req_be[4*c +: 4] = be;
    req_valid[c] = 1'b1;
  endtask

  task automatic test_reset();
    async_reset = 1'b0;
    req_valid = 4'b0101;
    tick();
    tick();
    n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0000", ack); end
    n_checks++; if (stall !== 4'b0101) begin n_fail++; $display("FAIL reset_stall got %b want 0101", stall); end
    n_checks++; if ({mem_en, mem_we, mem_be} !== 6'b0) begin n_fail++; $display("FAIL reset_mem_ctl got %b want 0", {mem_en, mem_we, mem_be}); end
    n_checks++; if ({mem_addr, mem_wdata, rdata} !== 74'b0) begin n_fail++; $display("FAIL reset_mem_data got %h want 0", {mem_addr, mem_wdata, rdata}); end
    req_valid = '0;
    #2 async_reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    ram[4] = 32'hDEADBEEF;
    set_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    tick();
    n_checks++; if ({mem_en, mem_we} !== 2'b10) begin n_fail++; $display("FAIL sr_en_we got %b want 10", {mem_en, mem_we}); end
    n_checks++; if (mem_addr !== 10'd4) begin n_fail++; $display("FAIL sr_addr got %0d want 4", mem_addr); end
    n_checks++; if (stall[0] !== 1'b1 || ack !== 4'b0) begin n_fail++; $display("FAIL sr_c1 got stall %b ack %b want 1 0000", stall[0], ack); end
    tick();
    n_checks++; if (stall[0] !== 1'b1 || ack !== 4'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL sr_c2 got stall %b ack %b en %b want 1 0000 0", stall[0], ack, mem_en); end
    tick();
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL sr_ack got %b want 0001", ack); end
    n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_rdata got %h want deadbeef", rdata); end
    n_checks++; if (stall[0] !== 1'b0) begin n_fail++; $display("FAIL sr_stall_release got %b want 0", stall[0]); end
    req_valid = '0;
    tick();
    n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL sr_ack_pulse got %b want 0000", ack); end
  endtask

  task automatic test_masked_write();
    ram[8] = 32'hAABBCCDD;
    set_req(1, 1'b1, 32'h8000_0022, 32'h12345678, 4'b0011);
    tick();
    n_checks++; if ({mem_en, mem_we} !== 2'b11) begin n_fail++; $display("FAIL mw_en_we got %b want 11", {mem_en, mem_we}); end
    n_checks++; if (mem_addr !== 10'd8) begin n_fail++; $display("FAIL mw_addr got %0d want 8", mem_addr); end
    n_checks++; if (mem_be !== 4'b0011 || mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL mw_be_data got %b %h want 0011 12345678", mem_be, mem_wdata); end
    tick();
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL mw_ack got %b want 0010", ack); end
    n_checks++; if ({mem_en, mem_we} !== 2'b00) begin n_fail++; $display("FAIL mw_we_one_cycle got %b want 00", {mem_en, mem_we}); end
    req_valid = '0;
    tick();
    set_req(2, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    tick();
    tick();
    tick();
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL mw_rb_ack got %b want 0100", ack); end
    n_checks++; if (rdata !== 32'hAABB5678) begin n_fail++; $display("FAIL mw_rb_rdata got %h want aabb5678", rdata); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] pend, exp_ack;
    async_reset = 1'b0;
    #2 async_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ram[16+c] = 32'hC0DE_0000 + c;
      set_req(c, 1'b0, 32'((16 + c) * 4), 32'h0, 4'hF);
    end
    pend = 4'hF;
    for (int t = 1; t <= 18; t++) begin
      tick();
      exp_ack = (t % 4 == 3 && t < 16) ? 4'(1 << (t / 4)) : 4'b0;
      n_checks++; if (ack !== exp_ack) begin n_fail++; $display("FAIL ct_ack t=%0d got %b want %b", t, ack, exp_ack); end
      n_checks++; if (stall !== (pend & ~exp_ack)) begin n_fail++; $display("FAIL ct_stall t=%0d got %b want %b", t, stall, pend & ~exp_ack); end
      for (int c = 0; c < 4; c++) if (exp_ack[c]) begin
        n_checks++; if (rdata !== 32'hC0DE_0000 + c) begin n_fail++; $display("FAIL ct_rdata core %0d got %h want %h", c, rdata, 32'hC0DE_0000 + c); end
        pend[c] = 1'b0;
        req_valid[c] = 1'b0;
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ack;
    set_req(2, 1'b0, 32'h0, 32'h0, 4'hF);
    tick();
    tick();
    tick();
    req_valid = '0;
    tick();
    ram[50] = 32'h0000_3333;
    ram[51] = 32'h0000_0000;
    set_req(3, 1'b0, 32'd200, 32'h0, 4'hF);
    set_req(0, 1'b0, 32'd204, 32'h0, 4'hF);
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_ack = (t == 3) ? 4'b1000 : (t == 7) ? 4'b0001 : 4'b0;
      n_checks++; if (ack !== exp_ack) begin n_fail++; $display("FAIL fair_ack t=%0d got %b want %b", t, ack, exp_ack); end
      if (t == 3) begin
        n_checks++; if (rdata !== 32'h0000_3333) begin n_fail++; $display("FAIL fair_rdata got %h want 00003333", rdata); end
      end
      req_valid = req_valid & ~exp_ack;
    end
  endtask

  task automatic test_dropped();
    ram[30] = 32'h5A5A1234;
    ram[31] = 32'h0F0F_7777;
    set_req(2, 1'b0, 32'h78, 32'h0, 4'hF);
    tick();
    tick();
    req_valid[2] = 1'b0;
    #1;
    n_checks++; if (stall[2] !== 1'b0) begin n_fail++; $display("FAIL drop_stall got %b want 0", stall[2]); end
    tick();
    n_checks++; if (ack !== 4'b0100 || rdata !== 32'h5A5A1234) begin n_fail++; $display("FAIL drop_ack got %b %h want 0100 5a5a1234", ack, rdata); end
    tick();
    set_req(1, 1'b0, 32'h7C, 32'h0, 4'hF);
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 10'd31) begin n_fail++; $display("FAIL drop_next_grant got %b %0d want 1 31", mem_en, mem_addr); end
    tick();
    tick();
    n_checks++; if (ack !== 4'b0010 || rdata !== 32'h0F0F_7777) begin n_fail++; $display("FAIL drop_next_ack got %b %h want 0010 0f0f7777", ack, rdata); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    ram[40] = 32'h1111_2222;
    ram[41] = 32'h4444_5555;
    set_req(1, 1'b0, 32'hA0, 32'h0, 4'hF);
    tick();
    tick();
    set_req(0, 1'b0, 32'hA4, 32'h0, 4'hF);
    #1 async_reset = 1'b0;
    #1;
    n_checks++; if ({mem_en, mem_we, mem_be, mem_addr} !== 16'b0 || mem_wdata !== 32'b0) begin n_fail++; $display("FAIL mr_mem got %b %b %b %0d %h want zeros", mem_en, mem_we, mem_be, mem_addr, mem_wdata); end
    n_checks++; if (rdata !== 32'b0 || ack !== 4'b0) begin n_fail++; $display("FAIL mr_rdata_ack got %h %b want 0 0000", rdata, ack); end
    n_checks++; if (stall !== 4'b0011) begin n_fail++; $display("FAIL mr_stall got %b want 0011", stall); end
    tick();
    tick();
    n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL mr_no_ack got %b want 0000", ack); end
    #2 async_reset = 1'b1;
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 10'd41) begin n_fail++; $display("FAIL mr_first_grant got %b %0d want 1 41", mem_en, mem_addr); end
    tick();
    tick();
    n_checks++; if (ack !== 4'b0001 || rdata !== 32'h4444_5555) begin n_fail++; $display("FAIL mr_ack0 got %b %h want 0001 44445555", ack, rdata); end
    req_valid[0] = 1'b0;
    for (int t = 4; t <= 7; t++) tick();
    n_checks++; if (ack !== 4'b0010 || rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL mr_ack1 got %b %h want 0010 11112222", ack, rdata); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    test_reset();
    test_single_read();
    test_masked_write();
    test_contention();
    test_fairness();
    test_dropped();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Round-robin arbiter that shares one synchronous single-port data RAM between `N_CORES` RV32I_Harvard cores in the multicore build. It sits between each core's data-memory port (`memory_transaction`, `mem_write`, `alu_result`, `data_out`, `byte_enablers`) and the shared RAM. It serializes accesses, stalls losing cores, and returns read data to the winning core.

## Interface
- `N_CORES`, default 4: number of requesting cores (2..8).
- `MEM_AW`, default 10: RAM word-address width.
- `clock`  in  1  single system clock; all state updates on rising edge.
- `async_reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_CORES  per-core request (core's `memory_transaction`).
- `req_write`  in  N_CORES  per-core write flag (core's `mem_write`).
- `req_addr`  in  32*N_CORES  flattened byte addresses; core i at [32i+31:32i].
- `req_wdata`  in  32*N_CORES  flattened write data.
- `req_be`  in  4*N_CORES  flattened byte enables.
- `stall`  out  N_CORES  freeze core i's pipeline.
- `ack`  out  N_CORES  one-cycle completion pulse for core i.
- `rdata`  out  32  read data, valid for the core whose `ack` is high.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  MEM_AW  RAM word address = latched `req_addr[MEM_AW+1:2]`.
- `mem_wdata`  out  32  RAM write data.
- `mem_be`  out  4  RAM byte enables.
- `mem_rdata`  in  32  RAM read data, one cycle after `mem_en` with `mem_we`=0.

## Operation
- FSM states: IDLE, ACCESS, READ_WAIT, DONE.
- IDLE: if any `req_valid`, select winner g by round robin. Search starts at `last_grant+1` mod N_CORES and wraps. Latch g, write flag, word address, wdata and be into registers. Go to ACCESS. With no request, stay in IDLE.
- ACCESS: `mem_en`=1, `mem_we`=latched write, address/data/be from latches. On a write, go to DONE. On a read, go to READ_WAIT.
- READ_WAIT: capture `mem_rdata` into `rdata` register; go to DONE.
- DONE: `ack[g]`=1 for exactly this cycle; `last_grant`<=g; go to IDLE.
- `stall[i]` = `req_valid[i] & ~ack[i]`, combinational. A requesting core is held until the cycle of its ack.
- Core must hold its request stable while stalled. Request inputs are sampled only in IDLE. Changes afterwards do not affect the in-flight access.
- If the winner drops `req_valid` mid-transaction, the access still completes and `ack` still pulses. A write still reaches RAM.
- `req_addr[1:0]` and bits above `MEM_AW+1` are ignored. Byte lane selection comes from `req_be` only.
- `rdata` holds its last captured value and is not cleared after a write.
- Every core must wait at most N_CORES-1 other transactions (starvation-free).

## Timing
- Reset (async assert, any state): state=IDLE, `last_grant`=N_CORES-1 (core 0 has first priority), `ack`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `rdata`=0. `stall` follows `req_valid` because `ack`=0.
- A reset in mid-access aborts it with no ack. A write in ACCESS may already have been clocked into RAM.
- Request sampled in IDLE at edge k:
  - `mem_en` is high in cycle k..k+1.
  - Write: `ack` in cycle k+1..k+2, 3 cycles total.
  - Read: `ack` and `rdata` valid in cycle k+2..k+3, 4 cycles total.
- Back-to-back: after DONE the arbiter returns to IDLE for one cycle before the next grant. Throughput is one write per 3 cycles or one read per 4 cycles.
- All memory-side outputs are registered. `stall` is the only combinational output.

## Test plan
- Single read: core0 reads addr 0x0000_0010 while RAM word 4 = 0xDEADBEEF. Required: `mem_addr`=4, `mem_we`=0; `ack[0]` 4 cycles after the request; `rdata`=0xDEADBEEF; `stall[0]` high until the ack cycle.
- Masked write: core1 writes 0x12345678 to 0x20 with be=4'b0011. Required: `mem_addr`=8, `mem_be`=0011, `mem_we`=1 for one cycle. A read-back by core2 returns 0xAABB5678 if the word was 0xAABBCCDD.
- Contention from reset: all four cores request reads simultaneously. Required: acks in order 0,1,2,3, 4 cycles apart, plus one IDLE cycle between transactions. Each stall releases only on its own ack.
- Fairness: `last_grant`=2, then cores 0 and 3 request together. Required: core 3 is served first, then core 0.
- Dropped request: core2 deasserts `req_valid` during READ_WAIT. Required: `ack[2]` still pulses; the next grant proceeds normally.
- Mid-access reset: assert `async_reset`=0 during READ_WAIT. Required: outputs go to reset values immediately, before the next edge, and no ack occurs. After release, a pending core 0 request is granted first.
